// File: rtl/snp_pair_packer_if.sv
// Beat handoff bus from the pair packer to the host write path.
// The producer drives data/valid/last; the host drives ready.
interface snp_pair_packer_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic [8*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/snp_pair_packer.sv
// Drains significant SNP pairs from the engine result FIFO and packs them
// 16 per 512-bit beat. A short final beat is padded with all ones and flagged last.
module snp_pair_packer #(
  parameter int PE_WIDTH   = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear_done,
  input  logic [PE_WIDTH-1:0]   pair_num_in,
  output logic                  pair_rd_en,
  input  logic [2*PE_WIDTH-1:0] pair_data_in,
  snp_pair_packer_if.master     out_if,
  output logic [PE_WIDTH-1:0]   beat_count,
  output logic                  ready,
  output logic                  done
);

  localparam int PAIR_W         = 2 * PE_WIDTH;
  localparam int PAIRS_PER_BEAT = 8 * DATA_WIDTH / PAIR_W;
  localparam int SLOT_W         = $clog2(PAIRS_PER_BEAT);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_DONE} state_e;

  state_e                                 state_q;
  logic [PE_WIDTH-1:0]                    total_q;
  logic [PE_WIDTH-1:0]                    issued_q;
  logic [PE_WIDTH-1:0]                    captured_q;
  logic [PE_WIDTH-1:0]                    beat_count_q;
  logic [SLOT_W:0]                        beat_iss_q;
  logic [SLOT_W-1:0]                      slot_q;
  logic                                   rd_pend_q;
  logic                                   last_q;
  logic [PAIRS_PER_BEAT-1:0][PAIR_W-1:0]  slots_q;

  logic cap_is_last;
  logic slot_is_full;

  assign cap_is_last  = (captured_q + PE_WIDTH'(1)) == total_q;
  assign slot_is_full = slot_q == SLOT_W'(PAIRS_PER_BEAT - 1);

  // Reads stop once a beat's worth is in flight; the next batch waits for acceptance.
  assign pair_rd_en = (state_q == S_FILL) && (issued_q < total_q)
                      && (beat_iss_q < (SLOT_W+1)'(PAIRS_PER_BEAT));

  assign out_if.out_data  = slots_q;
  assign out_if.out_valid = (state_q == S_EMIT);
  assign out_if.out_last  = last_q;
  assign beat_count       = beat_count_q;
  assign ready            = (state_q == S_IDLE);
  assign done             = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      total_q      <= '0;
      issued_q     <= '0;
      captured_q   <= '0;
      beat_count_q <= '0;
      beat_iss_q   <= '0;
      slot_q       <= '0;
      rd_pend_q    <= 1'b0;
      last_q       <= 1'b0;
      // NOTE: the beat register is flops, not RAM, so it can and must clear to 0 on reset.
      slots_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here; later ones in the block override earlier ones.
      rd_pend_q <= pair_rd_en;
      if (pair_rd_en) begin
        issued_q   <= issued_q + PE_WIDTH'(1);
        beat_iss_q <= beat_iss_q + (SLOT_W+1)'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            total_q      <= pair_num_in;
            issued_q     <= '0;
            captured_q   <= '0;
            beat_count_q <= '0;
            beat_iss_q   <= '0;
            slot_q       <= '0;
            last_q       <= 1'b0;
            slots_q      <= '1;
            state_q      <= (pair_num_in == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          // FIFO data arrives one cycle after its read strobe.
          if (rd_pend_q) begin
            slots_q[slot_q] <= pair_data_in;
            slot_q          <= slot_q + SLOT_W'(1);
            captured_q      <= captured_q + PE_WIDTH'(1);
            if (slot_is_full || cap_is_last) begin
              state_q <= S_EMIT;
              last_q  <= cap_is_last;
            end
          end
        end
        S_EMIT: begin
          if (out_if.out_ready) begin
            beat_count_q <= beat_count_q + PE_WIDTH'(1);
            slot_q       <= '0;
            beat_iss_q   <= '0;
            slots_q      <= '1;
            last_q       <= 1'b0;
            state_q      <= last_q ? S_DONE : S_FILL;
          end
        end
        S_DONE: begin
          if (clear_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
